serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes diff = a - b - bin, processing one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the team's ripple-carry adder.
- Trades latency for area in datapaths that already hold the adder. Driven by a start/done handshake from a local controller.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only when the block is not busy.
- a  input  WIDTH  minuend. Captured on an accepted start.
- b  input  WIDTH  subtrahend. Captured on an accepted start.
- bin  input  1  borrow in. Captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow. 1 iff a < b + bin (unsigned).
- zero  output  1  1 iff diff == 0.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE.
  - busy, done, diff, bout and zero are all 0.
  - Internal shift registers and borrow flip-flop are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b and bin into the shift registers and borrow flip-flop, clears the counter, and moves to RUN.
  - RUN: busy=1. Each cycle:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - Shift d into the result register from the MSB end; shift the operands right; increment the counter.
    - When counter == WIDTH-1, the final bit is processed and the state moves to DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0. diff, bout and zero update to the new result on entry to DONE. A start in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise the state moves to IDLE.
- Latency: start sampled at edge N; done is high in the cycle after edge N+WIDTH (WIDTH+1 edges from start to done). Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no capture and no effect on the in-flight operation.
- diff, bout and zero hold their last result until the next DONE; they do not change during RUN.
- Operands are sampled only on acceptance. Changes on a/b/bin afterwards have no effect.
- zero is computed from the final WIDTH-bit diff only, not from bout.
- Wrap-around: 0 - 0 - 1 gives diff = all ones, bout = 1.
- Reset asserted mid-RUN aborts immediately:
  - Outputs return to reset values and no done pulse is produced.
  - The first start after deassertion starts a fresh operation.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package serial_arith_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default width constant SERIAL_W_DEF = 4.
- One sub-module, full_subtractor: purely combinational 1-bit cell (a, b, bin -> d, bout), instantiated once. It is the dual of the adder's full-adder cell and is reusable for a ripple-borrow subtractor.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=4, a=6, b=2, bin=0, start pulse → busy high for 4 cycles, done one pulse at edge 5; diff=4, bout=0, zero=0.
- a=2, b=6, bin=0 → diff=12 (4'b1100), bout=1, zero=0. Then a=5, b=5, bin=0 → diff=0, bout=0, zero=1.
- a=0, b=0, bin=1 → diff=15, bout=1. Then start held high continuously → results every 5 cycles, and start pulses during RUN cause no extra capture or done.
- Reset asserted in the 2nd RUN cycle of a=9, b=3 → outputs 0 immediately, no done. After release, a=9, b=3 → diff=6, bout=0.
- Exhaustive sweep of all a, b in 0..15 and bin in 0..1, back-to-back starts accepted in DONE → diff, bout and zero match the model ((a-b-bin) mod 16, a<b+bin, diff==0) for every operation, and the done count equals the number of accepted starts.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic blocks.
// The FSM state constants and default width live here.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SERIAL_W_DEF = 4;

    // IDLE and DONE are the only states in which a new operation may be captured.
    function automatic logic state_accepts(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin with borrow out.
// Dual of the full-adder cell; usable in a ripple-borrow chain as well.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through a single
// full-subtractor cell; start/done handshake, results held until the next DONE.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter  int WIDTH = SERIAL_W_DEF,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Minuend shifts out of the LSB while result bits enter at the MSB,
    // so one register serves as both operand and result shift register.
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic             fs_d_s;
    logic             fs_bout_s;
    logic             accept_s;
    logic [WIDTH-1:0] shifted_s;

    full_subtractor u_fs (
        .a    (ar_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d_s),
        .bout (fs_bout_s)
    );

    assign accept_s  = start && state_accepts(state_q);
    assign shifted_s = {fs_d_s, ar_q[WIDTH-1:1]};

    // Next-state, datapath shift and result-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ar_d    = ar_q;
        b_d     = b_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    ar_d    = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                ar_d  = shifted_s;
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = fs_bout_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = shifted_s;
                    bout_d  = fs_bout_s;
                    zero_d  = (shifted_s == {WIDTH{1'b0}});
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ar_q    <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ar_q    <= ar_d;
            b_q     <= b_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule
